// File: rtl/lector_rtc.sv
// lector_rtc: periodic reader of the RTC multiplexed AD bus.
// Every PERIODO_LECTURA cycles it latches the RTC registers into the chip's
// read buffer, reads nine time/date/chronometer registers into shadows and,
// once the whole sweep is done, publishes them together with a one-cycle
// nuevo_dato strobe. nuevo_dato is a plain pulse: there is no back-pressure,
// the consumer samples the nine outputs on the cycle it sees the pulse or
// any time later until the next pulse.
module lector_rtc #(
    parameter int T_FASE          = 10,
    parameter int PERIODO_LECTURA = 1000000
) (
    input  logic       reloj_nexys,
    input  logic       reset_interno,
    input  logic       pausa,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] s_oro,
    output logic [7:0] m_oro,
    output logic [7:0] h_oro,
    output logic [7:0] giorno,
    output logic [7:0] messe,
    output logic [7:0] agno,
    output logic [7:0] secondo,
    output logic [7:0] minute,
    output logic [7:0] ora,
    output logic       nuevo_dato,
    output logic       ocupado,
    output logic [2:0] estado_dbg
);

    localparam int AF = (T_FASE > 1) ? $clog2(T_FASE) : 1;
    localparam int AP = (PERIODO_LECTURA > 1) ? $clog2(PERIODO_LECTURA) : 1;
    localparam logic [AF-1:0] FASE_FIN    = AF'(T_FASE - 1);
    localparam logic [AP-1:0] PERIODO_FIN = AP'(PERIODO_LECTURA - 1);
    localparam logic [3:0]    INDICE_FIN  = 4'd9;

    typedef enum logic [2:0] {
        ESPERA = 3'd0,
        DIR    = 3'd1,
        PAUSA1 = 3'd2,
        DATO   = 3'd3,
        PAUSA2 = 3'd4,
        COMMIT = 3'd5
    } estado_t;

    estado_t       estado;
    logic [AF-1:0] cnt_fase;
    logic [AP-1:0] cnt_periodo;
    logic [3:0]    indice;
    logic          solicitud;
    logic [7:0]    sombra [9];
    logic          fin_fase;
    logic          envolver;

    // Register address for each transaction of the sweep; index 0 is the
    // buffer-transfer write, the rest are the nine reads in output order.
    function automatic logic [7:0] dir_de(input logic [3:0] i);
        case (i)
            4'd0:    dir_de = 8'hF0;
            4'd1:    dir_de = 8'h21;
            4'd2:    dir_de = 8'h22;
            4'd3:    dir_de = 8'h23;
            4'd4:    dir_de = 8'h24;
            4'd5:    dir_de = 8'h25;
            4'd6:    dir_de = 8'h26;
            4'd7:    dir_de = 8'h41;
            4'd8:    dir_de = 8'h42;
            4'd9:    dir_de = 8'h43;
            default: dir_de = 8'h00;
        endcase
    endfunction

    assign fin_fase   = (cnt_fase == FASE_FIN);
    assign envolver   = (cnt_periodo == PERIODO_FIN);
    assign estado_dbg = estado;

    // Free-running period counter; its wrap raises a sweep request.
    always_ff @(posedge reloj_nexys or posedge reset_interno) begin
        if (reset_interno) begin
            cnt_periodo <= '0;
        end else if (envolver) begin
            cnt_periodo <= '0;
        end else begin
            cnt_periodo <= cnt_periodo + AP'(1);
        end
    end

    // Sweep sequencer: bus strobes are registered and set on entry to each
    // phase, so the pins always match the current state.
    always_ff @(posedge reloj_nexys or posedge reset_interno) begin
        if (reset_interno) begin
            estado     <= ESPERA;
            cnt_fase   <= '0;
            indice     <= '0;
            solicitud  <= 1'b0;
            cs_n       <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            a_d        <= 1'b0;
            ad_oe      <= 1'b0;
            ad_out     <= 8'h00;
            nuevo_dato <= 1'b0;
            ocupado    <= 1'b0;
            s_oro      <= 8'h00;
            m_oro      <= 8'h00;
            h_oro      <= 8'h00;
            giorno     <= 8'h00;
            messe      <= 8'h00;
            agno       <= 8'h00;
            secondo    <= 8'h00;
            minute     <= 8'h00;
            ora        <= 8'h00;
            for (int k = 0; k < 9; k++) begin
                sombra[k] <= 8'h00;
            end
        end else begin
            nuevo_dato <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (solicitud && !pausa) begin
                        solicitud <= 1'b0;
                        indice    <= 4'd0;
                        cnt_fase  <= '0;
                        estado    <= DIR;
                        cs_n      <= 1'b0;
                        wr_n      <= 1'b0;
                        a_d       <= 1'b0;
                        ad_oe     <= 1'b1;
                        ad_out    <= dir_de(4'd0);
                        ocupado   <= 1'b1;
                    end
                end
                DIR: begin
                    if (fin_fase) begin
                        cnt_fase <= '0;
                        estado   <= PAUSA1;
                        cs_n     <= 1'b1;
                        wr_n     <= 1'b1;
                        ad_oe    <= 1'b0;
                    end else begin
                        cnt_fase <= cnt_fase + AF'(1);
                    end
                end
                PAUSA1: begin
                    if (fin_fase) begin
                        cnt_fase <= '0;
                        estado   <= DATO;
                        cs_n     <= 1'b0;
                        a_d      <= 1'b1;
                        if (indice == 4'd0) begin
                            wr_n   <= 1'b0;
                            ad_oe  <= 1'b1;
                            ad_out <= 8'h00;
                        end else begin
                            rd_n <= 1'b0;
                        end
                    end else begin
                        cnt_fase <= cnt_fase + AF'(1);
                    end
                end
                DATO: begin
                    if (fin_fase) begin
                        // RTC data is settled by the last cycle of the read strobe.
                        if (indice != 4'd0) begin
                            sombra[indice - 4'd1] <= ad_in;
                        end
                        cnt_fase <= '0;
                        estado   <= PAUSA2;
                        cs_n     <= 1'b1;
                        rd_n     <= 1'b1;
                        wr_n     <= 1'b1;
                        ad_oe    <= 1'b0;
                    end else begin
                        cnt_fase <= cnt_fase + AF'(1);
                    end
                end
                PAUSA2: begin
                    if (fin_fase) begin
                        cnt_fase <= '0;
                        if (indice == INDICE_FIN) begin
                            estado <= COMMIT;
                        end else if (pausa) begin
                            // Writer wants the bus: drop the partial sweep.
                            estado  <= ESPERA;
                            ocupado <= 1'b0;
                        end else begin
                            indice <= indice + 4'd1;
                            estado <= DIR;
                            cs_n   <= 1'b0;
                            wr_n   <= 1'b0;
                            a_d    <= 1'b0;
                            ad_oe  <= 1'b1;
                            ad_out <= dir_de(indice + 4'd1);
                        end
                    end else begin
                        cnt_fase <= cnt_fase + AF'(1);
                    end
                end
                COMMIT: begin
                    s_oro      <= sombra[0];
                    m_oro      <= sombra[1];
                    h_oro      <= sombra[2];
                    giorno     <= sombra[3];
                    messe      <= sombra[4];
                    agno       <= sombra[5];
                    secondo    <= sombra[6];
                    minute     <= sombra[7];
                    ora        <= sombra[8];
                    nuevo_dato <= 1'b1;
                    ocupado    <= 1'b0;
                    estado     <= ESPERA;
                end
                default: begin
                    estado <= ESPERA;
                end
            endcase
            // A wrap always leaves one request pending; extra wraps merge into it.
            if (envolver) begin
                solicitud <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lector_rtc.sv
// Bench for lector_rtc: directed scenarios plus random pausa/bus noise,
// checked cycle by cycle against a sweep-position model.
`timescale 1ns/1ps
module tb_lector_rtc;

    localparam int T     = 2;
    localparam int P     = 100;
    localparam int PB    = 50;
    localparam int Q     = 4 * T;
    localparam int SWEEP = 10 * Q;

    localparam logic [71:0] VALORES_1 = 72'h45_30_12_21_05_16_09_08_07;
    localparam logic [71:0] VALORES_2 = 72'h59_58_23_31_12_99_33_44_55;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    // DUT A (period 100)
    logic       pausa;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d;
    logic [7:0] s_oro, m_oro, h_oro, giorno, messe, agno, secondo, minute, ora;
    logic       nuevo_dato, ocupado;
    logic [2:0] estado_dbg;
    logic [71:0] salidas;
    assign salidas = {s_oro, m_oro, h_oro, giorno, messe, agno, secondo, minute, ora};

    // DUT B (period 50, shorter than a sweep)
    logic       b_pausa;
    logic [7:0] b_ad_in;
    logic [7:0] b_ad_out;
    logic       b_ad_oe, b_cs_n, b_rd_n, b_wr_n, b_a_d;
    logic [7:0] b_s_oro, b_m_oro, b_h_oro, b_giorno, b_messe, b_agno, b_secondo, b_minute, b_ora;
    logic       b_nd, b_ocu;
    logic [2:0] b_estado_dbg;

    lector_rtc #(.T_FASE(T), .PERIODO_LECTURA(P)) dut (
        .reloj_nexys(clk), .reset_interno(rst), .pausa(pausa), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .s_oro(s_oro), .m_oro(m_oro), .h_oro(h_oro), .giorno(giorno), .messe(messe),
        .agno(agno), .secondo(secondo), .minute(minute), .ora(ora),
        .nuevo_dato(nuevo_dato), .ocupado(ocupado), .estado_dbg(estado_dbg)
    );

    lector_rtc #(.T_FASE(T), .PERIODO_LECTURA(PB)) dut_b (
        .reloj_nexys(clk), .reset_interno(rst_b), .pausa(b_pausa), .ad_in(b_ad_in),
        .ad_out(b_ad_out), .ad_oe(b_ad_oe), .cs_n(b_cs_n), .rd_n(b_rd_n), .wr_n(b_wr_n), .a_d(b_a_d),
        .s_oro(b_s_oro), .m_oro(b_m_oro), .h_oro(b_h_oro), .giorno(b_giorno), .messe(b_messe),
        .agno(b_agno), .secondo(b_secondo), .minute(b_minute), .ora(b_ora),
        .nuevo_dato(b_nd), .ocupado(b_ocu), .estado_dbg(b_estado_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nombre, input logic [71:0] actual, input logic [71:0] esperado);
        n_checks++;
        if (actual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", nombre, actual, esperado, $time);
        end
    endtask

    // RTC chip model driving ad_in
    logic [7:0] mem [256];
    logic [7:0] lat_addr = 8'h00;
    logic       ruido;

    task automatic cargar_mem(input logic [71:0] v);
        logic [7:0] dirs [9];
        dirs = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        for (int k = 0; k < 9; k++) begin
            mem[dirs[k]] = v[71 - 8*k -: 8];
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        ad_in = 8'h00;
        b_ad_in = 8'h00;
        forever begin
            @(negedge clk);
            if (!cs_n && !a_d && ad_oe) lat_addr = ad_out;
            if (ruido) ad_in = 8'($urandom);
            else if (!rd_n) ad_in = mem[lat_addr];
            else ad_in = 8'hA5;
            b_ad_in = 8'($urandom);
        end
    end

    // behavioural model: position inside the sweep, -1 when idle
    logic [7:0] addr_tab [10];
    int         m_pos;
    int         m_pcnt;
    bit         m_flag;
    logic [7:0] m_sh  [9];
    logic [7:0] m_out [9];
    bit         m_nd;
    int         nd_total = 0;

    initial addr_tab = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    task automatic modelo_reset();
        m_pos = -1; m_pcnt = 0; m_flag = 0; m_nd = 0;
        for (int k = 0; k < 9; k++) begin m_sh[k] = 8'h00; m_out[k] = 8'h00; end
    endtask

    task automatic modelo_paso();
        bit wrap;
        bit took;
        int i;
        int r;
        wrap = (m_pcnt == P - 1);
        m_pcnt = wrap ? 0 : m_pcnt + 1;
        took = 0;
        m_nd = 0;
        if (m_pos < 0) begin
            if (m_flag && !pausa) begin took = 1; m_pos = 0; end
        end else if (m_pos == SWEEP) begin
            for (int k = 0; k < 9; k++) m_out[k] = m_sh[k];
            m_nd = 1;
            m_pos = -1;
        end else begin
            i = m_pos / Q;
            r = m_pos % Q;
            if (r == 3*T - 1 && i >= 1) m_sh[i-1] = ad_in;
            if (r == Q - 1 && i != 9 && pausa) m_pos = -1;
            else m_pos = m_pos + 1;
        end
        m_flag = (m_flag && !took) || wrap;
    endtask

    task automatic comparar();
        logic e_cs, e_rd, e_wr, e_oe, e_ad_d, e_ocu;
        logic [7:0] e_ad;
        logic [71:0] e_sal;
        int i;
        int ph;
        e_cs = 1; e_rd = 1; e_wr = 1; e_oe = 0; e_ad_d = 0; e_ad = 8'h00;
        e_ocu = (m_pos >= 0);
        if (m_pos >= 0 && m_pos < SWEEP) begin
            i  = m_pos / Q;
            ph = (m_pos % Q) / T;
            if (ph == 0) begin
                e_cs = 0; e_wr = 0; e_oe = 1; e_ad_d = 0; e_ad = addr_tab[i];
            end else if (ph == 2) begin
                e_cs = 0; e_ad_d = 1;
                if (i == 0) begin e_wr = 0; e_oe = 1; e_ad = 8'h00; end
                else e_rd = 0;
            end
        end
        for (int k = 0; k < 9; k++) e_sal[71 - 8*k -: 8] = m_out[k];
        chk("cs_n", cs_n, e_cs);
        chk("rd_n", rd_n, e_rd);
        chk("wr_n", wr_n, e_wr);
        chk("ad_oe", ad_oe, e_oe);
        chk("ocupado", ocupado, e_ocu);
        chk("nuevo_dato", nuevo_dato, m_nd);
        chk("salidas", salidas, e_sal);
        chk("rd_con_oe", (!rd_n && ad_oe), 1'b0);
        if (!e_cs) chk("a_d", a_d, e_ad_d);
        if (e_oe) chk("ad_out", ad_out, e_ad);
    endtask

    // compare process for DUT A
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) modelo_reset();
            else modelo_paso();
            comparar();
            if (nuevo_dato === 1'b1) nd_total++;
        end
    end

    // back-to-back checker for DUT B
    int nb_edges, nb_commits, low_run;
    bit prev_nd, prev_ocu, seen;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_b) begin
                nb_edges = 0; nb_commits = 0; low_run = 0;
                prev_nd = 0; prev_ocu = 0; seen = 0;
            end else begin
                nb_edges++;
                if (b_nd === 1'b1) begin
                    chk("nd_b_consecutivo", prev_nd, 1'b0);
                    nb_commits++;
                end
                if (b_ocu === 1'b1) begin
                    if (!prev_ocu && seen) chk("hueco_b", low_run, 1);
                    low_run = 0;
                end else begin
                    low_run++;
                end
                if (b_nd === 1'b1) seen = 1;
                prev_nd = b_nd;
                prev_ocu = b_ocu;
            end
        end
    end

    function automatic bit cond(input int sel);
        case (sel)
            0: return ocupado === 1'b1;
            1: return nuevo_dato === 1'b1;
            2: return ocupado === 1'b0;
            3: return m_pos >= Q && m_pos < SWEEP && ((m_pos % Q) / T) == 2;
            4: return m_pos >= 4*Q && m_pos < 5*Q;
            default: return 1'b0;
        endcase
    endfunction

    // counts edges until cond(sel) holds, sampled 2 ns after each edge
    task automatic esperar(input int sel, input int limite, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!cond(sel) && n < limite);
        if (!cond(sel)) chk("espera_agotada", sel, 72'hFF);
    endtask

    task automatic resumen();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout required finish at %0t", $time);
        n_fail++;
        resumen();
        $finish;
    end

    // stimulus
    initial begin
        int n;
        int nd_antes;
        int esperado_b;
        rst = 1; rst_b = 1; pausa = 0; b_pausa = 0; ruido = 0;
        cargar_mem(VALORES_1);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_rd_n", rd_n, 1'b1);
        chk("rst_wr_n", wr_n, 1'b1);
        chk("rst_a_d", a_d, 1'b0);
        chk("rst_ad_oe", ad_oe, 1'b0);
        chk("rst_ad_out", ad_out, 8'h00);
        chk("rst_salidas", salidas, 72'h0);
        chk("rst_nd", nuevo_dato, 1'b0);
        chk("rst_ocupado", ocupado, 1'b0);
        @(negedge clk);
        rst = 0; rst_b = 0;

        // first sweep: DIR at edge 101, publish 81 edges later
        esperar(0, 200, n);
        chk("primer_dir", n, 101);
        chk("primer_ad_out", ad_out, 8'hF0);
        esperar(1, 200, n);
        chk("latencia_nd", n, 81);
        chk("valores_1", salidas, VALORES_1);
        cargar_mem(VALORES_2);

        // pausa raised in transaction 4: abort after it completes
        nd_antes = nd_total;
        esperar(4, 200, n);
        @(negedge clk);
        pausa = 1;
        esperar(2, 50, n);
        chk("aborto_tras_t4", n, 8);
        chk("aborto_sin_nd", nd_total - nd_antes, 0);
        chk("aborto_salidas", salidas, VALORES_1);
        repeat (5) @(negedge clk);
        pausa = 0;
        esperar(1, 400, n);
        chk("valores_2", salidas, VALORES_2);

        // pausa over two wraps: one immediate sweep, next only after a new wrap
        @(negedge clk);
        pausa = 1;
        repeat (127) @(negedge clk);
        pausa = 0;
        @(posedge clk);
        #2;
        chk("inicio_inmediato", ocupado, 1'b1);
        esperar(2, 200, n);
        chk("barrido_largo", n, 81);
        esperar(0, 200, n);
        chk("siguiente_tras_wrap", n, 10);

        // reset in the middle of a DATO read
        esperar(3, 100, n);
        #3;
        rst = 1;
        #1;
        chk("rst_async_cs_n", cs_n, 1'b1);
        chk("rst_async_rd_n", rd_n, 1'b1);
        chk("rst_async_ocupado", ocupado, 1'b0);
        chk("rst_async_salidas", salidas, 72'h0);
        chk("rst_async_ad_oe", ad_oe, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        esperar(0, 200, n);
        chk("dir_tras_reset", n, 101);

        // randomized pausa and bus noise
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            ruido = ($urandom_range(0, 1) == 1);
            pausa = ($urandom_range(0, 3) == 0);
            cargar_mem({$urandom, $urandom, $urandom});
            repeat ($urandom_range(1, 150)) @(negedge clk);
        end
        pausa = 0;
        ruido = 0;
        repeat (300) @(negedge clk);

        @(posedge clk);
        #3;
        esperado_b = (nb_edges >= 132) ? (nb_edges - 132) / 82 + 1 : 0;
        chk("commits_b", nb_commits, esperado_b);
        resumen();
        $finish;
    end

endmodule

// File: doc/lector_rtc.md
# lector_rtc

Periodic reader for the external RTC chip's multiplexed address/data bus. It sweeps the time, date and chronometer registers on a fixed period and holds them in shadow registers. After a complete sweep it publishes all nine values atomically as BCD to the VGA display path, with a one-cycle update strobe. It is the producer side of the display's time inputs and sits between the RTC pins and the VGA controller, on the same 100 MHz board clock.

## Interface
- T_FASE, 10: clock cycles per bus phase (minimum 2).
- PERIODO_LECTURA, 1000000: clock cycles between sweep requests (10 ms at 100 MHz).
- reloj_nexys  in  1  board clock, 100 MHz; all logic on rising edge.
- reset_interno  in  1  reset, asynchronous, active-high.
- pausa  in  1  high = programming writer owns the bus; no new sweep starts.
- ad_in  in  8  RTC AD bus, read path.
- ad_out  out  8  RTC AD bus, drive value.
- ad_oe  out  1  1 = this block drives AD.
- cs_n, rd_n, wr_n  out  1 each  RTC chip select, read strobe and write strobe; all active-low.
- a_d  out  1  0 = address phase, 1 = data phase.
- s_oro, m_oro, h_oro  out  8 each  clock seconds, minutes and hours (BCD).
- giorno, messe, agno  out  8 each  day, month and year (BCD).
- secondo, minute, ora  out  8 each  chronometer seconds, minutes and hours (BCD).
- nuevo_dato  out  1  one-cycle pulse when the outputs are updated.
- ocupado  out  1  high while a sweep is in progress.

## Operation
- The sweep is 10 transactions, indexed 0..9.
  - Index 0 is a write of address 0xF0, data 0x00. This transfers the RTC registers to the RTC's read buffer.
  - Indices 1..9 are reads of 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43.
  - The reads land in the shadows for s_oro, m_oro, h_oro, giorno, messe, agno, secondo, minute, ora, in that order.
- FSM states: ESPERA, DIR, PAUSA1, DATO, PAUSA2, COMMIT.
- ESPERA:
  - cs_n = rd_n = wr_n = 1, ad_oe = 0, ocupado = 0.
  - If the request flag is set and pausa = 0: clear the flag, set index to 0, go to DIR.
- DIR:
  - cs_n = 0, a_d = 0, wr_n = 0, ad_oe = 1, ad_out = address of the current index.
  - Lasts T_FASE cycles, then go to PAUSA1.
- PAUSA1:
  - All strobes = 1, ad_oe = 0.
  - Lasts T_FASE cycles, then go to DATO.
- DATO:
  - cs_n = 0, a_d = 1.
  - Index 0: wr_n = 0, ad_oe = 1, ad_out = 0x00.
  - Index ≥ 1: rd_n = 0, ad_oe = 0. ad_in is captured into the indexed shadow on the last (T_FASE-th) cycle of the phase.
  - Lasts T_FASE cycles, then go to PAUSA2.
- PAUSA2:
  - All strobes = 1, ad_oe = 0.
  - Lasts T_FASE cycles.
  - Then: if index = 9, go to COMMIT.
  - Else if pausa = 1, abort: discard the shadows and go to ESPERA.
  - Else increment index and go to DIR.
- COMMIT:
  - All nine shadows copy to the outputs in the same edge.
  - nuevo_dato = 1 for this single cycle.
  - Then go to ESPERA.
- ocupado = 1 in DIR, PAUSA1, DATO, PAUSA2 and COMMIT.
- Period counter:
  - Free-running from 0 to PERIODO_LECTURA-1, then wraps.
  - On the wrap it sets the request flag. The flag holds at most one pending request; an extra wrap while the flag is set is lost.
- pausa is sampled only in ESPERA and at the end of PAUSA2. A transaction that has started always runs to completion.
- Values are passed through unchanged. No BCD validation is done.

## Timing
- Reset values:
  - cs_n = rd_n = wr_n = 1, a_d = 0, ad_oe = 0, ad_out = 0x00.
  - All nine time outputs = 0x00.
  - nuevo_dato = 0, ocupado = 0.
  - Period counter = 0, request flag = 0, state = ESPERA.
- Reset mid-sweep releases the bus in the same asynchronous instant, and the outputs return to 0x00.
- Transaction length: 4·T_FASE cycles. Sweep length: 40·T_FASE + 1 cycles, which is 401 at the defaults.
- The first request occurs PERIODO_LECTURA cycles after reset is released.
- DIR is entered on the cycle after ESPERA observes the flag with pausa = 0.
- nuevo_dato rises on the same edge that updates the outputs. Outputs are stable from that edge until the next COMMIT or reset.
- No phase overlaps another: a_d changes only while cs_n = 1 or at a phase boundary, and ad_oe = 0 whenever rd_n = 0.

## Test plan
- Reset, T_FASE=2, PERIODO_LECTURA=100, RTC model returns 0x45,0x30,0x12,0x21,0x05,0x16,0x09,0x08,0x07 for 0x21..0x43.
  - First DIR at cycle 101.
  - nuevo_dato pulses once, 81 cycles later.
  - Outputs are s_oro=0x45, m_oro=0x30, h_oro=0x12, giorno=0x21, messe=0x05, agno=0x16, secondo=0x09, minute=0x08, ora=0x07.
- Bus protocol check on every sweep:
  - Index 0 shows ad_out=0xF0 with wr_n=0, a_d=0, then ad_out=0x00 with wr_n=0, a_d=1.
  - rd_n is never low while ad_oe=1.
  - Each strobe-low phase is exactly T_FASE cycles.
- pausa raised during transaction 4:
  - Transaction 4 completes, then the FSM returns to ESPERA.
  - No nuevo_dato; outputs keep their previous values.
  - After pausa drops, the next wrap produces a full sweep.
- pausa held high across two wraps, then released:
  - Exactly one sweep starts immediately.
  - The next sweep starts only after a further wrap.
- Reset asserted in the middle of a DATO read:
  - cs_n and rd_n go to 1, outputs go to 0x00, ocupado goes to 0, all asynchronously.
  - After release, the first sweep starts PERIODO_LECTURA cycles later.
- PERIODO_LECTURA=50, T_FASE=2 (sweep of 81 cycles, longer than the period):
  - Sweeps run back-to-back with one ESPERA cycle between them.
  - nuevo_dato is never high on two consecutive cycles.
